// File: rtl/life_pkg.sv
// Shared types and constants for the 8x8 Game of Life engine.
// Provides the FSM state enum, board geometry and the (row,col)->bit map.
package life_pkg;

    localparam int BOARD_DIM  = 8;
    localparam int BOARD_BITS = BOARD_DIM * BOARD_DIM;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    // Row-major cell placement: cell (r,c) lives at bit r*8+c.
    function automatic logic [5:0] cell_idx(input int r, input int c);
        return 6'(r * BOARD_DIM + c);
    endfunction

endpackage

// File: rtl/life_next_gen.sv
// Combinational next-generation evaluator for an 8x8 Life board.
// Ports: grid (current board) -> next (board after one generation).
module life_next_gen
    import life_pkg::*;
#(
    parameter int WRAP = 0
) (
    input  logic [BOARD_BITS-1:0] grid,
    output logic [BOARD_BITS-1:0] next
);

    logic [3:0] cnt;
    int         rr;
    int         cc;

    always_comb begin
        next = '0;
        cnt  = '0;
        rr   = 0;
        cc   = 0;
        for (int r = 0; r < BOARD_DIM; r++) begin
            for (int c = 0; c < BOARD_DIM; c++) begin
                cnt = '0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        // Toroidal mode folds the edge onto the far side.
                        if (WRAP != 0) begin
                            rr = (rr + BOARD_DIM) % BOARD_DIM;
                            cc = (cc + BOARD_DIM) % BOARD_DIM;
                        end
                        if (!(dr == 0 && dc == 0) &&
                            rr >= 0 && rr < BOARD_DIM &&
                            cc >= 0 && cc < BOARD_DIM) begin
                            cnt = cnt + 4'(grid[cell_idx(rr, cc)]);
                        end
                    end
                end
                // Birth on 3; survival on 2 or 3.
                next[cell_idx(r, c)] = (cnt == 4'd3) ||
                                       (grid[cell_idx(r, c)] &&
                                        cnt == 4'd2);
            end
        end
    end

endmodule

// File: rtl/life_grid_engine.sv
// Game of Life engine: latches a seed, evolves it per tick, halts on still life/extinction.
// Ports: clk, reset(async low), load, seed, run, single_step -> grid, gen_count, stable, extinct, busy.
module life_grid_engine
    import life_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000,
    parameter int GEN_W    = 16,
    parameter int WRAP     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [BOARD_BITS-1:0] seed,
    input  logic                  run,
    input  logic                  single_step,
    output logic [BOARD_BITS-1:0] grid,
    output logic [GEN_W-1:0]      gen_count,
    output logic                  stable,
    output logic                  extinct,
    output logic                  busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    state_t                  state_q, state_d;
    logic [BOARD_BITS-1:0]   grid_q, grid_d;
    logic [GEN_W-1:0]        gen_q, gen_d;
    logic [PW-1:0]           pre_q, pre_d;
    logic                    stable_q, stable_d;
    logic                    extinct_q, extinct_d;
    logic                    busy_q;
    logic                    do_apply;
    logic [BOARD_BITS-1:0]   nxt;

    life_next_gen #(
        .WRAP (WRAP)
    ) u_next (
        .grid (grid_q),
        .next (nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            grid_q    <= '0;
            gen_q     <= '0;
            pre_q     <= '0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            gen_q     <= gen_d;
            pre_q     <= pre_d;
            stable_q  <= stable_d;
            extinct_q <= extinct_d;
            busy_q    <= (state_d == RUN);
        end
    end

    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        gen_d     = gen_q;
        pre_d     = pre_q;
        stable_d  = stable_q;
        extinct_d = extinct_q;
        do_apply  = 1'b0;

        if (load) begin
            grid_d    = seed;
            gen_d     = '0;
            pre_d     = '0;
            stable_d  = 1'b0;
            extinct_d = (seed == '0);
            state_d   = (seed == '0) ? HALT : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (run) begin
                        state_d = RUN;
                        pre_d   = '0;
                    end else if (single_step) begin
                        do_apply = 1'b1;
                    end
                end
                RUN: begin
                    // Dropping run discards any partially counted tick.
                    if (!run) begin
                        state_d = IDLE;
                        pre_d   = '0;
                    end else if (pre_q == PRE_LAST) begin
                        do_apply = 1'b1;
                        pre_d    = '0;
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                HALT: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (do_apply) begin
                if (nxt == grid_q) begin
                    stable_d = 1'b1;
                    state_d  = HALT;
                end else begin
                    grid_d = nxt;
                    gen_d  = (&gen_q) ? gen_q : gen_q + 1'b1;
                    if (nxt == '0) begin
                        extinct_d = 1'b1;
                        state_d   = HALT;
                    end
                end
            end
        end
    end

    assign grid      = grid_q;
    assign gen_count = gen_q;
    assign stable    = stable_q;
    assign extinct   = extinct_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// Scoreboard bench for life_grid_engine across three parameter sets.
// Expected states are queued when stimulus is driven and compared after the edge.
module tb_life_grid_engine;

    localparam logic [63:0] BLK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLK_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK = 64'h0000_0000_0000_0303;
    localparam logic [63:0] CORNR = 64'h8100_0000_0000_0081;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [63:0] seed;
    logic        run;
    logic        single_step;

    logic [63:0] a_grid, w_grid, s_grid;
    logic [15:0] a_gen, w_gen;
    logic [2:0]  s_gen;
    logic        a_st, a_ex, a_bz;
    logic        w_st, w_ex, w_bz;
    logic        s_st, s_ex, s_bz;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        int          dut;
        logic [63:0] grid;
        logic [63:0] gen;
        logic        st;
        logic        ex;
        logic        bz;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    life_grid_engine #(.TICK_DIV(4), .GEN_W(16), .WRAP(0)) u_a (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run),
        .single_step(single_step), .grid(a_grid), .gen_count(a_gen),
        .stable(a_st), .extinct(a_ex), .busy(a_bz)
    );

    life_grid_engine #(.TICK_DIV(4), .GEN_W(16), .WRAP(1)) u_w (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run),
        .single_step(single_step), .grid(w_grid), .gen_count(w_gen),
        .stable(w_st), .extinct(w_ex), .busy(w_bz)
    );

    life_grid_engine #(.TICK_DIV(1), .GEN_W(3), .WRAP(0)) u_s (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run),
        .single_step(single_step), .grid(s_grid), .gen_count(s_gen),
        .stable(s_st), .extinct(s_ex), .busy(s_bz)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_st(input string tag, input int dut,
                             input logic [63:0] g, input logic [63:0] n,
                             input logic st, input logic ex,
                             input logic bz);
        exp_t e;
        e.tag  = tag;
        e.dut  = dut;
        e.grid = g;
        e.gen  = n;
        e.st   = st;
        e.ex   = ex;
        e.bz   = bz;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [63:0] g, n;
        logic        st, ex, bz;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                1: begin
                    g = w_grid; n = 64'(w_gen);
                    st = w_st; ex = w_ex; bz = w_bz;
                end
                2: begin
                    g = s_grid; n = 64'(s_gen);
                    st = s_st; ex = s_ex; bz = s_bz;
                end
                default: begin
                    g = a_grid; n = 64'(a_gen);
                    st = a_st; ex = a_ex; bz = a_bz;
                end
            endcase
            chk({e.tag, ".grid"}, g, e.grid);
            chk({e.tag, ".gen"}, n, e.gen);
            chk({e.tag, ".stable"}, 64'(st), 64'(e.st));
            chk({e.tag, ".extinct"}, 64'(ex), 64'(e.ex));
            chk({e.tag, ".busy"}, 64'(bz), 64'(e.bz));
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic do_load(input logic [63:0] s);
        seed = s;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic pulse_step();
        single_step = 1'b1;
        step(1);
        single_step = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        load        = 1'b0;
        seed        = '0;
        run         = 1'b0;
        single_step = 1'b0;
        step(2);
        expect_st("rst", 0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        drain();
        reset = 1'b1;
        step(1);

        // Blinker oscillation under continuous run.
        do_load(BLK_H);
        expect_st("blk_load", 0, BLK_H, 64'd0, 1'b0, 1'b0, 1'b0);
        drain();
        run = 1'b1;
        step(1);
        expect_st("blk_entry", 0, BLK_H, 64'd0, 1'b0, 1'b0, 1'b1);
        drain();
        step(3);
        expect_st("blk_pre", 0, BLK_H, 64'd0, 1'b0, 1'b0, 1'b1);
        drain();
        step(1);
        expect_st("blk_g1", 0, BLK_V, 64'd1, 1'b0, 1'b0, 1'b1);
        drain();
        step(4);
        expect_st("blk_g2", 0, BLK_H, 64'd2, 1'b0, 1'b0, 1'b1);
        drain();
        run = 1'b0;
        step(1);

        // Block still life, then ignored controls in HALT.
        do_load(BLOCK);
        pulse_step();
        expect_st("block", 0, BLOCK, 64'd0, 1'b1, 1'b0, 1'b0);
        drain();
        pulse_step();
        run = 1'b1;
        step(3);
        run = 1'b0;
        step(1);
        expect_st("block_hold", 0, BLOCK, 64'd0, 1'b1, 1'b0, 1'b0);
        drain();

        // Extinction by step, then by empty load.
        do_load(64'h1);
        pulse_step();
        expect_st("die", 0, 64'h0, 64'd1, 1'b0, 1'b1, 1'b0);
        drain();
        do_load(64'h0);
        expect_st("empty", 0, 64'h0, 64'd0, 1'b0, 1'b1, 1'b0);
        drain();
        run = 1'b1;
        step(2);
        run = 1'b0;
        expect_st("empty_halt", 0, 64'h0, 64'd0, 1'b0, 1'b1, 1'b0);
        drain();

        // Corner cells: dead edge vs toroidal block.
        do_load(CORNR);
        pulse_step();
        expect_st("corner_nw", 0, 64'h0, 64'd1, 1'b0, 1'b1, 1'b0);
        expect_st("corner_w", 1, CORNR, 64'd0, 1'b1, 1'b0, 1'b0);
        drain();

        // Dropping run discards the partial tick.
        do_load(BLK_H);
        run = 1'b1;
        step(3);
        run = 1'b0;
        step(1);
        expect_st("drop_run", 0, BLK_H, 64'd0, 1'b0, 1'b0, 1'b0);
        drain();

        // Load beats run mid-RUN.
        run = 1'b1;
        step(3);
        seed = BLK_H;
        load = 1'b1;
        step(1);
        load = 1'b0;
        run  = 1'b0;
        expect_st("load_prio", 0, BLK_H, 64'd0, 1'b0, 1'b0, 1'b0);
        drain();
        step(4);
        expect_st("load_idle", 0, BLK_H, 64'd0, 1'b0, 1'b0, 1'b0);
        drain();

        // Asynchronous reset mid-run, sampled between edges.
        run = 1'b1;
        step(6);
        expect_st("pre_rst", 0, BLK_V, 64'd1, 1'b0, 1'b0, 1'b1);
        drain();
        #2;
        reset = 1'b0;
        #1;
        expect_st("async_rst", 0, 64'h0, 64'd0, 1'b0, 1'b0, 1'b0);
        drain();
        run = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);

        // Saturating 3-bit generation counter at one tick per cycle.
        do_load(BLK_H);
        run = 1'b1;
        step(1);
        step(10);
        expect_st("sat10", 2, BLK_H, 64'd7, 1'b0, 1'b0, 1'b1);
        drain();
        step(1);
        expect_st("sat11", 2, BLK_V, 64'd7, 1'b0, 1'b0, 1'b1);
        drain();
        run = 1'b0;
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
